// File: rtl/prog_mem.sv
// Program memory: fills every word with FILL after reset, then serves single-cycle fetches and accepts burst loads.
// Optional per-word even parity: define PROG_MEM_PARITY_EN.
module prog_mem #(
  parameter int            DW   = 16,
  parameter int            AW   = 8,
  parameter logic [DW-1:0] FILL = 16'hF000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_data,
  output logic          fetch_valid,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          busy,
  output logic          par_err
);

  localparam int DEPTH = 2**AW;
`ifdef PROG_MEM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_init_cnt;
  logic [AW-1:0]   r_ptr;
  logic            r_ld_done;
  logic [DW-1:0]   r_fetch_data_p1;
  logic            r_fetch_vld_p1;
  logic [MW-1:0]   r_mem [DEPTH];

  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [DW-1:0]   w_wdata;
  logic [MW-1:0]   w_wword;
  logic [MW-1:0]   w_rword;
  logic            w_fetch_acc;
  logic            w_ld_acc;
  logic            w_ld_end;

`ifdef PROG_MEM_PARITY_EN
  function automatic logic even_par(input logic [DW-1:0] d);
    return ^d;
  endfunction
  assign w_wword = {even_par(w_wdata), w_wdata};
`else
  assign w_wword = w_wdata;
`endif

  // Single write port shared by the init sweep and load beats; they never overlap.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_init_cnt;
    w_wdata     = FILL;
    w_fetch_acc = 1'b0;
    w_ld_acc    = 1'b0;
    w_ld_end    = 1'b0;
    case (r_state)
      S_INIT: begin
        w_we = 1'b1;
        if (r_init_cnt == {AW{1'b1}}) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        w_fetch_acc = fetch_req;
        if (ld_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_ld_acc = ld_valid;
        w_we     = ld_valid;
        w_waddr  = r_ptr;
        w_wdata  = ld_data;
        // The session stops at the top of memory rather than wrapping onto address 0.
        if (ld_valid && (ld_last || r_ptr == {AW{1'b1}})) begin
          w_ld_end    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_ptr      <= '0;
      r_ld_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ld_done <= w_ld_end;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      if (r_state == S_IDLE && ld_start) r_ptr <= ld_base;
      else if (w_ld_acc)                 r_ptr <= r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wword;
  end

  assign w_rword = r_mem[fetch_addr];

  // Stage p1: registered fetch response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_data_p1 <= '0;
      r_fetch_vld_p1  <= 1'b0;
    end else begin
      r_fetch_vld_p1 <= w_fetch_acc;
      if (w_fetch_acc) r_fetch_data_p1 <= w_rword[DW-1:0];
    end
  end

`ifdef PROG_MEM_PARITY_EN
  logic r_par_err_p1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_par_err_p1 <= 1'b0;
    else if (w_fetch_acc) r_par_err_p1 <= ^w_rword;
    else                  r_par_err_p1 <= 1'b0;
  end
  assign par_err = r_par_err_p1;
`else
  assign par_err = 1'b0;
`endif

  assign fetch_data  = r_fetch_data_p1;
  assign fetch_valid = r_fetch_vld_p1;
  assign ld_ready    = (r_state == S_LOAD);
  assign ld_done     = r_ld_done;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem (DW=16, AW=4): stimulus pushes expected fetch words, a monitor pops on fetch_valid.
module tb_prog_mem;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_done;
  logic          busy;
  logic          par_err;

  int errors = 0;
  int checks = 0;
  logic [DW:0] exp_q [$];

  logic [DW-1:0] beats [12] = '{16'h3000, 16'h3101, 16'h4202, 16'h5303, 16'h6108, 16'h7205,
                                16'h8306, 16'h9407, 16'hA508, 16'hB609, 16'hC70A, 16'hF00B};

  prog_mem #(.DW(DW), .AW(AW), .FILL(16'hF000)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .ld_start(ld_start), .ld_base(ld_base),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy), .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one accepted fetch in IDLE and queue the expected {par_err, data}.
  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic pe);
    fetch_req  = 1'b1;
    fetch_addr = a;
    exp_q.push_back({pe, d});
    tick();
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 100);
    chk(name, n, 16);
  endtask

  // Monitor: every fetch_valid beat must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (fetch_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch_valid: got data %h with no request outstanding", fetch_data);
      end else begin
        e = exp_q.pop_front();
        chk("fetch_data", {16'h0, fetch_data}, {16'h0, e[DW-1:0]});
        chk("fetch_par_err", {31'h0, par_err}, {31'h0, e[DW]});
      end
    end else if (rst_n) begin
      chk("par_err_idle", {31'h0, par_err}, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; ld_start = 1'b0; ld_base = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 1);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_par_err", par_err, 0);

    rst_n = 1'b1;
    wait_init("init_cycles");
    fetch(4'd5, 16'hF000, 1'b0);

    // 12-beat load from base 0 ending with ld_last
    ld_start = 1'b1; ld_base = 4'd0;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ld_valid = 1'b1; ld_data = beats[i]; ld_last = (i == 11);
      chk("ld1_ready", ld_ready, 1);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("ld1_done", ld_done, 1);
    chk("ld1_ready_drop", ld_ready, 0);
    chk("ld1_busy_low", busy, 0);
    tick();
    chk("ld1_done_pulse", ld_done, 0);
    fetch(4'd4, 16'h6108, 1'b0);
    fetch(4'd12, 16'hF000, 1'b0);
    fetch(4'd11, 16'hF00B, 1'b0);
    fetch(4'd0, 16'h3000, 1'b0);

    // Load from base 14 without ld_last: stops at top of memory
    ld_start = 1'b1; ld_base = 4'd14;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 16'hAAAA;
    chk("ld2_ready_b1", ld_ready, 1);
    tick();
    ld_data = 16'hBBBB;
    chk("ld2_ready_b2", ld_ready, 1);
    tick();
    ld_data = 16'hCCCC;
    chk("ld2_ready_drop", ld_ready, 0);
    chk("ld2_done", ld_done, 1);
    tick();
    ld_valid = 1'b0;
    chk("ld2_done_pulse", ld_done, 0);
    fetch(4'd14, 16'hAAAA, 1'b0);
    fetch(4'd15, 16'hBBBB, 1'b0);
    fetch(4'd0, 16'h3000, 1'b0);

    // Fetch together with ld_start, then fetch_req held through LOAD
    fetch_req = 1'b1; fetch_addr = 4'd5; ld_start = 1'b1; ld_base = 4'd8;
    exp_q.push_back({1'b0, 16'h7205});
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ld3_fetch_blocked", fetch_valid, 0);
      chk("ld3_busy", busy, 1);
    end
    ld_valid = 1'b1; ld_data = 16'h1234; ld_last = 1'b1;
    tick();
    fetch_req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    chk("ld3_fetch_blocked_last", fetch_valid, 0);
    chk("ld3_done", ld_done, 1);
    tick();
    fetch(4'd8, 16'h1234, 1'b0);

    // Reset in the middle of a load session
    ld_start = 1'b1; ld_base = 4'd2;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 16'h1111 * (i + 1);
      tick();
    end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_ld_ready", ld_ready, 0);
    chk("mid_rst_ld_done", ld_done, 0);
    tick();
    chk("mid_rst_ld_done_hold", ld_done, 0);
    rst_n = 1'b1;
    wait_init("reinit_cycles");
    chk("reinit_ld_done", ld_done, 0);
    fetch(4'd2, 16'hF000, 1'b0);
    fetch(4'd3, 16'hF000, 1'b0);
    fetch(4'd8, 16'hF000, 1'b0);

`ifdef PROG_MEM_PARITY_EN
    dut.r_mem[6][DW] = ~dut.r_mem[6][DW];
    fetch(4'd6, 16'hF000, 1'b1);
    fetch(4'd7, 16'hF000, 1'b0);
`endif

    tick(); tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter DW, default 16, instruction word width in bits.
REQ-002 Parameter AW, default 8, address width; depth DEPTH = 2**AW words.
REQ-003 Parameter FILL, default 16'hF000 (halt), word written to every location during init.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 fetch_req  input  1  read request from core.
REQ-007 fetch_addr  input  AW  read address.
REQ-008 fetch_data  output  DW  registered read data.
REQ-009 fetch_valid  output  1  fetch_data valid, one-cycle pulse.
REQ-010 ld_start  input  1  begin load session.
REQ-011 ld_base  input  AW  load start address, sampled with ld_start.
REQ-012 ld_valid  input  1  load beat offered.
REQ-013 ld_data  input  DW  load beat data.
REQ-014 ld_last  input  1  marks final beat of session.
REQ-015 ld_ready  output  1  load beat accepted when ld_valid & ld_ready.
REQ-016 ld_done  output  1  one-cycle pulse at session end.
REQ-017 busy  output  1  high in INIT and LOAD.
REQ-018 par_err  output  1  parity mismatch on current fetch_valid beat.

Function
REQ-019 FSM states INIT, IDLE, LOAD; INIT entered on reset.
REQ-020 INIT: writes FILL to address init_cnt, init_cnt 0..DEPTH-1, one word per cycle; after DEPTH-1 written -> IDLE (DEPTH cycles total).
REQ-021 IDLE: fetch_req high at edge N -> fetch_data = mem[fetch_addr], fetch_valid = 1 after edge N; fetch_valid low on cycles without accepted request.
REQ-022 fetch_data holds last value when fetch_valid low.
REQ-023 fetch_req in INIT or LOAD is ignored; fetch_valid stays 0; no queued replay.
REQ-024 IDLE & ld_start -> LOAD, write pointer <= ld_base; ld_start ignored in INIT and LOAD.
REQ-025 IDLE with fetch_req and ld_start same cycle: fetch served (valid next cycle) and FSM enters LOAD.
REQ-026 LOAD: ld_ready = 1; accepted beat writes mem[ptr] <= ld_data, ptr <= ptr+1.
REQ-027 LOAD ends after accepted beat with ld_last = 1, or after accepted beat at ptr = DEPTH-1 (no wrap); then ld_ready = 0, ld_done pulses next cycle, FSM -> IDLE.
REQ-028 ld_ready is 0 in INIT and IDLE; beats offered then are dropped.
REQ-029 Memory contents are not preserved across reset; INIT reruns in full.

Reset
REQ-030 rst_n low: state INIT, init_cnt 0, ptr 0, fetch_data 0, fetch_valid 0, ld_ready 0, ld_done 0, busy 1, par_err 0.
REQ-031 rst_n asserted mid-LOAD or mid-INIT aborts the operation immediately; no ld_done pulse.

Configuration
REQ-032 Macro PROG_MEM_PARITY_EN defined: each word stores DW+1 bits, extra bit = even parity of data, computed on every write (INIT and LOAD); on fetch, par_err = stored parity XOR recomputed parity, valid only with fetch_valid, otherwise 0.
REQ-033 Macro undefined: memory is DW bits wide, no parity logic, par_err tied 0.

Verification (DW=16, AW=4, FILL=16'hF000)
REQ-034 Release rst_n -> busy=1 exactly 16 cycles, then fetch addr 5 -> fetch_data 16'hF000, fetch_valid 1 one cycle later.
REQ-035 ld_start base 0, 12 beats (16'h3000..16'hF00B), ld_last on 12th -> ld_done 1 cycle; fetch addr 4 of beat 16'h6108 returns 16'h6108; addr 12 returns 16'hF000.
REQ-036 ld_start base 14, 3 beats, no ld_last -> addrs 14,15 written, ld_ready drops after 2nd beat, third beat not accepted, ld_done pulses.
REQ-037 fetch_req held high during LOAD -> fetch_valid stays 0; fetch_req with ld_start in IDLE -> one fetch_valid pulse, then LOAD.
REQ-038 rst_n low mid-LOAD after 3 beats -> no ld_done, busy 1 for 16 cycles, fetch of loaded addr returns 16'hF000.
REQ-039 PROG_MEM_PARITY_EN defined: all fetches in REQ-034..REQ-038 report par_err 0; forced stored-bit flip via bench hierarchy -> par_err 1 on that fetch.
